// File: rtl/multi_start_reg.sv
// Multi-channel start latch: each channel turns a rising start edge into a sticky or
// time-limited go level, with a one-cycle entry strobe and an expiry flag.
module multi_start_reg #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int RETRIGGER = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] clear,
    input  logic [CNT_W-1:0]    hold_cycles,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] expired,
    output logic                any_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    logic [CHANNELS-1:0] start_prev;
    logic [CHANNELS-1:0] out_nxt;

    // start_prev clears on reset so a start held through reset release counts as an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_prev <= '0;
            any_active <= 1'b0;
        end else begin
            start_prev <= start;
            any_active <= |out_nxt;
        end
    end

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             sticky, sticky_nxt;
        logic             pulse_nxt;
        logic             trig;
        logic             out_q, pulse_q, expired_q;

        assign trig = start[i] & ~start_prev[i] & enable;

        // clear has priority over triggers and over a same-cycle expiry
        always_comb begin
            state_nxt  = state;
            cnt_nxt    = cnt;
            sticky_nxt = sticky;
            pulse_nxt  = 1'b0;
            if (clear[i]) begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                sticky_nxt = 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig) begin
                            state_nxt  = ACTIVE;
                            cnt_nxt    = hold_cycles;
                            sticky_nxt = (hold_cycles == '0);
                            pulse_nxt  = 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (trig && (RETRIGGER != 0)) begin
                            cnt_nxt    = hold_cycles;
                            sticky_nxt = (hold_cycles == '0);
                            pulse_nxt  = 1'b1;
                        end else if (!sticky) begin
                            if (cnt == CNT_W'(1)) begin
                                state_nxt = EXPIRED;
                                cnt_nxt   = '0;
                            end else begin
                                cnt_nxt = cnt - CNT_W'(1);
                            end
                        end
                    end
                    EXPIRED: begin
                        state_nxt = EXPIRED;
                    end
                    default: begin
                        state_nxt  = IDLE;
                        cnt_nxt    = '0;
                        sticky_nxt = 1'b0;
                    end
                endcase
            end
        end

        assign out_nxt[i] = (state_nxt == ACTIVE);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state     <= IDLE;
                cnt       <= '0;
                sticky    <= 1'b0;
                out_q     <= 1'b0;
                pulse_q   <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                sticky    <= sticky_nxt;
                out_q     <= (state_nxt == ACTIVE);
                pulse_q   <= pulse_nxt;
                expired_q <= (state_nxt == EXPIRED);
            end
        end

        assign out[i]     = out_q;
        assign pulse[i]   = pulse_q;
        assign expired[i] = expired_q;
    end

endmodule

// File: tb/tb_multi_start_reg.sv
// Bench for multi_start_reg: a RETRIGGER=0 and a RETRIGGER=1 instance share stimulus and
// are checked every cycle against a remaining-cycles model plus hand-computed counts.
module tb_multi_start_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] start;
    logic [3:0] clear;
    logic [7:0] hold;

    logic [3:0] out0, pulse0, exp0;
    logic [3:0] out1, pulse1, exp1;
    logic       any0, any1;

    int checks = 0;
    int errors = 0;

    int outCnt   [2][4];
    int pulseCnt [2][4];
    int anyCnt   [2];

    // Model: cycles of window left per channel, with sticky meaning "no end"
    int         remM [2][4];
    bit         stkM [2][4];
    bit         expM [2][4];
    bit         pulM [2][4];
    logic [3:0] prevM;

    always #5 clk = ~clk;

    multi_start_reg #(.CHANNELS(4), .CNT_W(8), .RETRIGGER(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .clear(clear),
        .hold_cycles(hold), .out(out0), .pulse(pulse0), .expired(exp0), .any_active(any0)
    );

    multi_start_reg #(.CHANNELS(4), .CNT_W(8), .RETRIGGER(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .clear(clear),
        .hold_cycles(hold), .out(out1), .pulse(pulse1), .expired(exp1), .any_active(any1)
    );

    always @(posedge clk or negedge rst) begin : model
        bit trig;
        bit act;
        if (!rst) begin
            for (int r = 0; r < 2; r++)
                for (int ch = 0; ch < 4; ch++) begin
                    remM[r][ch] = 0;
                    stkM[r][ch] = 1'b0;
                    expM[r][ch] = 1'b0;
                    pulM[r][ch] = 1'b0;
                end
            prevM = 4'b0;
        end else begin
            for (int r = 0; r < 2; r++)
                for (int ch = 0; ch < 4; ch++) begin
                    trig = start[ch] && !prevM[ch] && enable;
                    act  = stkM[r][ch] || (remM[r][ch] > 0);
                    pulM[r][ch] = 1'b0;
                    if (clear[ch]) begin
                        remM[r][ch] = 0;
                        stkM[r][ch] = 1'b0;
                        expM[r][ch] = 1'b0;
                    end else if (trig && ((!act && !expM[r][ch]) || (act && r == 1))) begin
                        stkM[r][ch] = (hold == 0);
                        remM[r][ch] = int'(hold);
                        pulM[r][ch] = 1'b1;
                    end else if (act && !stkM[r][ch]) begin
                        remM[r][ch] = remM[r][ch] - 1;
                        if (remM[r][ch] == 0) expM[r][ch] = 1'b1;
                    end
                end
            prevM = start;
        end
    end

    function automatic logic [3:0] modelOut(int r);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++) v[ch] = stkM[r][ch] || (remM[r][ch] > 0);
        return v;
    endfunction

    function automatic logic [3:0] modelPulse(int r);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++) v[ch] = pulM[r][ch];
        return v;
    endfunction

    function automatic logic [3:0] modelExp(int r);
        logic [3:0] v;
        for (int ch = 0; ch < 4; ch++) v[ch] = expM[r][ch];
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle out of reset, both instances must match the model
    always @(posedge clk) begin
        #1;
        if (rst) begin
            checkOutput("out0",     int'(out0),   int'(modelOut(0)));
            checkOutput("pulse0",   int'(pulse0), int'(modelPulse(0)));
            checkOutput("expired0", int'(exp0),   int'(modelExp(0)));
            checkOutput("any0",     int'(any0),   int'(|modelOut(0)));
            checkOutput("out1",     int'(out1),   int'(modelOut(1)));
            checkOutput("pulse1",   int'(pulse1), int'(modelPulse(1)));
            checkOutput("expired1", int'(exp1),   int'(modelExp(1)));
            checkOutput("any1",     int'(any1),   int'(|modelOut(1)));
        end
    end

    task automatic resetCounts();
        for (int r = 0; r < 2; r++) begin
            anyCnt[r] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                outCnt[r][ch]   = 0;
                pulseCnt[r][ch] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] c);
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            outCnt[0][ch]   += int'(out0[ch]);
            outCnt[1][ch]   += int'(out1[ch]);
            pulseCnt[0][ch] += int'(pulse0[ch]);
            pulseCnt[1][ch] += int'(pulse1[ch]);
        end
        anyCnt[0] += int'(any0);
        anyCnt[1] += int'(any1);
        start = s;
        clear = c;
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        start  = 4'b0;
        clear  = 4'b0;
        hold   = 8'd0;
        resetCounts();
        repeat (2) @(negedge clk);
        checkOutput("reset_out",   int'({out0, out1}), 0);
        checkOutput("reset_pulse", int'({pulse0, pulse1}), 0);
        checkOutput("reset_exp",   int'({exp0, exp1}), 0);
        checkOutput("reset_any",   int'({any0, any1}), 0);
        rst    = 1'b1;
        enable = 1'b1;

        // Sticky window on channel 0
        hold = 8'd0;
        resetCounts();
        applyStimulus(4'b0001, 4'b0);
        repeat (56) applyStimulus(4'b0, 4'b0);
        checkOutput("sticky_out0",   int'(out0[0]), 1);
        checkOutput("sticky_out1",   int'(out1[0]), 1);
        checkOutput("sticky_pulses", pulseCnt[0][0], 1);
        checkOutput("sticky_highs",  outCnt[0][0], 56);
        checkOutput("sticky_exp",    int'(exp0[0]), 0);
        applyStimulus(4'b0, 4'b0001);
        applyStimulus(4'b0, 4'b0);
        checkOutput("sticky_clear", int'(out0[0]), 0);

        // Five-cycle window on channel 1, expiry is held and ignores new edges
        hold = 8'd5;
        resetCounts();
        applyStimulus(4'b0010, 4'b0);
        repeat (9) applyStimulus(4'b0, 4'b0);
        checkOutput("win5_len0", outCnt[0][1], 5);
        checkOutput("win5_len1", outCnt[1][1], 5);
        checkOutput("win5_exp",  int'(exp0[1]), 1);
        applyStimulus(4'b0010, 4'b0);
        repeat (3) applyStimulus(4'b0, 4'b0);
        checkOutput("win5_ignore_out",   int'(out0[1]), 0);
        checkOutput("win5_ignore_pulse", pulseCnt[1][1], 1);
        applyStimulus(4'b0, 4'b0010);
        applyStimulus(4'b0, 4'b0);
        checkOutput("win5_clear_exp", int'({exp0[1], exp1[1]}), 0);

        // Retrigger two cycles into a four-cycle window on channel 2
        hold = 8'd4;
        resetCounts();
        applyStimulus(4'b0100, 4'b0);
        applyStimulus(4'b0, 4'b0);
        applyStimulus(4'b0100, 4'b0);
        repeat (10) applyStimulus(4'b0, 4'b0);
        checkOutput("retrig1_len",    outCnt[1][2], 6);
        checkOutput("retrig1_pulses", pulseCnt[1][2], 2);
        checkOutput("retrig0_len",    outCnt[0][2], 4);
        checkOutput("retrig0_pulses", pulseCnt[0][2], 1);
        applyStimulus(4'b0, 4'b0100);
        applyStimulus(4'b0, 4'b0);

        // Clear beats a simultaneous edge; disabled edges are ignored
        resetCounts();
        applyStimulus(4'b1000, 4'b1000);
        repeat (3) applyStimulus(4'b0, 4'b0);
        checkOutput("clr_vs_edge_pulse", pulseCnt[0][3], 0);
        checkOutput("clr_vs_edge_out",   outCnt[0][3], 0);
        enable = 1'b0;
        resetCounts();
        applyStimulus(4'b1000, 4'b0);
        repeat (3) applyStimulus(4'b1000, 4'b0);
        checkOutput("disabled_any", anyCnt[0] + anyCnt[1], 0);
        applyStimulus(4'b0, 4'b0);
        enable = 1'b1;

        // Start held through reset release, then async reset mid-window
        rst   = 1'b0;
        start = 4'b0001;
        hold  = 8'd10;
        @(negedge clk);
        rst = 1'b1;
        resetCounts();
        applyStimulus(4'b0, 4'b0);
        checkOutput("relstart_out",   int'(out0[0]), 1);
        checkOutput("relstart_pulse", int'(pulse1[0]), 1);
        repeat (3) applyStimulus(4'b0, 4'b0);
        checkOutput("midwin_before", int'({out0[0], out1[0]}), 3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_out",   int'({out0, out1}), 0);
        checkOutput("async_pulse", int'({pulse0, pulse1}), 0);
        checkOutput("async_exp",   int'({exp0, exp1}), 0);
        checkOutput("async_any",   int'({any0, any1}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) applyStimulus(4'b0, 4'b0);
        checkOutput("no_resume", int'({out0[0], out1[0]}), 0);

        // Staggered three-cycle windows on all channels
        hold = 8'd3;
        resetCounts();
        applyStimulus(4'b0001, 4'b0);
        applyStimulus(4'b0010, 4'b0);
        applyStimulus(4'b0100, 4'b0);
        applyStimulus(4'b1000, 4'b0);
        repeat (8) applyStimulus(4'b0, 4'b0);
        for (int ch = 0; ch < 4; ch++) begin
            checkOutput($sformatf("stagger_len0_ch%0d", ch), outCnt[0][ch], 3);
            checkOutput($sformatf("stagger_len1_ch%0d", ch), outCnt[1][ch], 3);
        end
        checkOutput("stagger_any0", anyCnt[0], 6);
        checkOutput("stagger_any1", anyCnt[1], 6);
        checkOutput("stagger_exp",  int'(exp1), 15);
        applyStimulus(4'b0, 4'b1111);
        applyStimulus(4'b0, 4'b0);
        checkOutput("final_exp", int'({exp0, exp1}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_start_reg.md
Name: multi_start_reg

Overview:
- Parametrised, multi-channel successor to the single sticky start latch.
- Each channel detects a rising edge on its start input and raises a latched `out` level with a one-cycle `pulse`.
- Each channel optionally holds `out` for a programmable number of cycles, then flags expiry until explicitly cleared.
- Sits between the top-level control inputs and downstream engines that need either a sticky go level or a bounded go window.

Parameters:
- CHANNELS, 4, number of independent start channels (1..32)
- CNT_W, 8, width of the hold-cycle counter and the hold_cycles input
- RETRIGGER, 0, 1 = a start edge while ACTIVE reloads the counter; 0 = the edge is ignored

Ports:
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk in the system)
- enable  input  1  global enable; start edges are accepted only while 1
- start  input  CHANNELS  per-channel start request, level input
- clear  input  CHANNELS  per-channel synchronous clear back to IDLE
- hold_cycles  input  CNT_W  shared window length, sampled at the trigger edge; 0 = sticky (no timeout)
- out  output  CHANNELS  per-channel latched active level
- pulse  output  CHANNELS  one-cycle strobe on entry to ACTIVE
- expired  output  CHANNELS  per-channel level, high in EXPIRED
- any_active  output  1  OR of all out bits (registered)

Behaviour:
- Reset (rst=0): every channel goes to IDLE.
  - out, pulse, expired, any_active and the counters all = 0.
  - The start_prev registers = 0, so a start already held high at reset release counts as a rising edge on the first enabled clock.
- Edge detect per channel: edge[i] = start[i] & ~start_prev[i]; start_prev[i] <= start[i] every cycle regardless of state or enable.
- State machine per channel, fully independent; the three states are IDLE, ACTIVE, EXPIRED.
- IDLE:
  - edge & enable & ~clear moves the channel to ACTIVE at that clock edge.
  - On that transition: cnt <= hold_cycles, sticky <= (hold_cycles==0), pulse=1 for exactly the following cycle.
- ACTIVE:
  - out=1.
  - If not sticky: cnt decrements each cycle.
  - When cnt==1, the next edge goes to EXPIRED. out is therefore high for exactly hold_cycles cycles.
  - If sticky: the channel stays ACTIVE until clear.
- EXPIRED:
  - out=0, expired=1.
  - start edges are ignored; only clear leaves this state.
- clear[i]=1 moves the channel to IDLE from any state at the next edge.
  - clear wins over a simultaneous start edge, including from IDLE.
  - It also wins over a same-cycle expiry.
- Retrigger in ACTIVE (edge & enable):
  - RETRIGGER=1: cnt reloads from hold_cycles, sticky is recomputed, pulse fires again, the window restarts.
  - RETRIGGER=0: no effect.
- enable=0 blocks new triggers only. ACTIVE countdown and expiry continue; clear still works.
- Outputs out, pulse, expired and any_active are all registered. Latency: start rises before edge k → out/pulse high after edge k.
- Async reset mid-window: outputs drop immediately and the counter is lost. There is no resume after reset.
- hold_cycles changes while ACTIVE have no effect until the next trigger.

Test Plan:
- Reset, then enable=1, hold_cycles=0, start[0] pulsed 1 cycle → out[0] rises 1 cycle later and stays high for 50+ cycles, pulse[0] high 1 cycle, expired[0]=0; clear[0] → out[0]=0 next cycle.
- hold_cycles=5, start[1] edge → out[1] high exactly 5 cycles, then expired[1]=1 held; a further start[1] edge has no effect; clear[1] → IDLE, expired[1]=0.
- RETRIGGER=1, hold_cycles=4, second start[2] edge on cycle 3 of the window → pulse[2] fires again, out[2] total high = 2+4 = 6 cycles. Repeat with RETRIGGER=0 → 4 cycles, single pulse.
- start[3] edge and clear[3] in the same cycle from IDLE → stays IDLE, no pulse. enable=0 with a start edge → no response, any_active=0.
- start held high through reset release with enable=1 → trigger on the first clock. Async rst=0 asserted mid-window (hold_cycles=10, cycle 4) → all outputs 0 immediately, without waiting for a clock edge.
- All 4 channels triggered on staggered cycles with hold_cycles=3 → independent 3-cycle windows; any_active high from the first out to the last out, matching the OR of the out bits.
